// File: rtl/usb_tb_ctrl_if.sv
// rtl/usb_tb_ctrl_if.sv - Line, node and status signals between a test top and usb_tb_ctrl
interface usb_tb_ctrl_if #(
    parameter int NUM_NODES = 2,
    parameter int CNT_WIDTH = 32
);
    logic                 linep;
    logic                 linem;
    logic [NUM_NODES-1:0] node_done;
    logic [NUM_NODES-1:0] node_nreset;
    logic [CNT_WIDTH-1:0] count;
    logic [2:0]           state;
    logic                 pass;
    logic                 timeout;
    logic                 se0_reset_det;
    logic                 bus_idle;

    modport master (
        output linep, linem, node_done,
        input  node_nreset, count, state, pass, timeout, se0_reset_det, bus_idle
    );

    modport slave (
        input  linep, linem, node_done,
        output node_nreset, count, state, pass, timeout, se0_reset_det, bus_idle
    );
endinterface

// File: rtl/usb_tb_ctrl.sv
// rtl/usb_tb_ctrl.sv - Staggered node resets, run watchdog and D+/D- bus-reset/idle monitor
module usb_tb_ctrl #(
    parameter int NUM_NODES        = 2,
    parameter int CNT_WIDTH        = 32,
    parameter int RESET_CYCLES     = 10,
    parameter int RESET_STAGGER    = 0,
    parameter int TIMEOUT_CYCLES   = 12000,
    parameter int SE0_RESET_CYCLES = 30,
    parameter int IDLE_CYCLES      = 64
) (
    input  logic         clk,
    input  logic         nreset,
    usb_tb_ctrl_if.slave bus
);

    localparam logic [2:0] ST_HOLD    = 3'd0;
    localparam logic [2:0] ST_RELEASE = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam int SW = $clog2(SE0_RESET_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_TGT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0]        SE0_TGT     = SW'(SE0_RESET_CYCLES);
    localparam logic [IW-1:0]        IDLE_TGT    = IW'(IDLE_CYCLES);
    localparam logic [1:0]           LINE_SE0    = 2'b00;

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [2:0]           state_q, state_d;
    logic [NUM_NODES-1:0] node_nreset_q, node_nreset_d;
    logic                 pass_q, pass_d;
    logic                 timeout_q, timeout_d;
    logic [1:0]           line_s1_q, line_s1_d;
    logic [1:0]           line_s2_q, line_s2_d;
    logic [1:0]           line_prev_q, line_prev_d;
    logic [SW-1:0]        se0_cnt_q, se0_cnt_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 se0_det_q, se0_det_d;

    logic active;
    logic mon_run;

    function automatic logic [CNT_WIDTH-1:0] rel_target(input int idx);
        return CNT_WIDTH'(RESET_CYCLES + idx * RESET_STAGGER);
    endfunction

    // Sequencer: counter, node release, done/watchdog decisions
    always_comb begin
        active        = (state_q == ST_HOLD) || (state_q == ST_RELEASE) || (state_q == ST_RUN);
        count_d       = count_q;
        node_nreset_d = node_nreset_q;
        state_d       = state_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;

        if (active && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end

        if (active) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                if (count_d == rel_target(i)) begin
                    node_nreset_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            ST_HOLD: begin
                if (&node_nreset_d) begin
                    state_d = ST_RUN;
                end else if (node_nreset_d[0]) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (&node_nreset_d) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (&bus.node_done) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // Completion sampled on the same edge as expiry takes precedence
        if (active && (state_d != ST_DONE) && (count_d == TIMEOUT_TGT)) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
        end
    end

    // Line monitor: counters only live while the run stays in RUN across the edge
    always_comb begin
        line_s1_d   = {bus.linep, bus.linem};
        line_s2_d   = line_s1_q;
        line_prev_d = line_s2_q;
        mon_run     = (state_q == ST_RUN) && (state_d == ST_RUN);
        se0_cnt_d   = '0;
        idle_cnt_d  = '0;
        se0_det_d   = 1'b0;

        if (mon_run) begin
            if (line_s2_q == LINE_SE0) begin
                se0_cnt_d = (se0_cnt_q == {SW{1'b1}}) ? se0_cnt_q : se0_cnt_q + 1'b1;
            end

            // A fresh line state counts its first stable cycle immediately
            if (line_s2_q != line_prev_q) begin
                idle_cnt_d = IW'(1);
            end else begin
                idle_cnt_d = (idle_cnt_q == {IW{1'b1}}) ? idle_cnt_q : idle_cnt_q + 1'b1;
            end

            se0_det_d = (se0_cnt_d == SE0_TGT) && (se0_cnt_q != SE0_TGT);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q       <= '0;
            state_q       <= ST_HOLD;
            node_nreset_q <= '0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            line_s1_q     <= '0;
            line_s2_q     <= '0;
            line_prev_q   <= '0;
            se0_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            se0_det_q     <= 1'b0;
        end else begin
            count_q       <= count_d;
            state_q       <= state_d;
            node_nreset_q <= node_nreset_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            line_s1_q     <= line_s1_d;
            line_s2_q     <= line_s2_d;
            line_prev_q   <= line_prev_d;
            se0_cnt_q     <= se0_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            se0_det_q     <= se0_det_d;
        end
    end

    assign bus.count         = count_q;
    assign bus.state         = state_q;
    assign bus.node_nreset   = node_nreset_q;
    assign bus.pass          = pass_q;
    assign bus.timeout       = timeout_q;
    assign bus.se0_reset_det = se0_det_q;
    assign bus.bus_idle      = (idle_cnt_q >= IDLE_TGT);

endmodule
